// File: rtl/food_consumer.sv
// rtl/food_consumer.sv - captures a food map, counts crux cells, consumes cells under the player and keeps score.
// Optional build macro FOOD_CONSUMER_REMAIN_EN adds the food_left remaining-cell counter.
module food_consumer #(
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [299:0]       food_in,
    input  logic               load,
    input  logic               pos_valid,
    input  logic [3:0]         pos_x,
    input  logic [3:0]         pos_y,
    output logic [299:0]       food_map,
    output logic               ready,
    output logic               eaten,
    output logic [1:0]         eaten_kind,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         crux_left,
    output logic               win,
    output logic [7:0]         food_left
);

    typedef enum logic [1:0] {IDLE, SCAN, READY, DONE} state_t;

    state_t       state;
    logic [7:0]   idx;
    logic [1:0]   scan_code;
    logic         pos_legal;
    logic [7:0]   cell_idx;
    logic [7:0]   sel;
    logic [1:0]   pos_code;
    logic         eat_ok;
    logic [3:0]   points;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [299:0] clear_mask;

    always_comb begin
        scan_code = food_map[{idx, 1'b0} +: 2];
        pos_legal = (pos_x <= 4'd9) && (pos_y <= 4'd14);
        cell_idx  = ({4'd0, pos_y} * 8'd10) + {4'd0, pos_x};
        // Out-of-range coordinates are steered to cell 0 so the part-select never leaves the map.
        sel       = pos_legal ? cell_idx : 8'd0;
        pos_code  = food_map[{sel, 1'b0} +: 2];
        eat_ok    = (state == READY) && pos_valid && pos_legal && (pos_code != 2'b00);
        case (pos_code)
            2'b01:   points = 4'd1;
            2'b10:   points = 4'd5;
            2'b11:   points = 4'd10;
            default: points = 4'd0;
        endcase
        score_sum  = {1'b0, score} + (SCORE_W+1)'(points);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        clear_mask = ~(300'b11 << {sel, 1'b0});
    end

    assign ready = (state == READY);
    assign win   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 8'd0;
            food_map   <= '0;
            score      <= '0;
            crux_left  <= 3'd0;
            eaten      <= 1'b0;
            eaten_kind <= 2'b00;
        end else begin
            eaten      <= 1'b0;
            eaten_kind <= 2'b00;
            if (load) begin
                food_map  <= food_in;
                idx       <= 8'd0;
                crux_left <= 3'd0;
                state     <= SCAN;
            end else begin
                case (state)
                    IDLE: ;
                    SCAN: begin
                        if (scan_code == 2'b11)
                            crux_left <= crux_left + 3'd1;
                        if (idx == 8'd149)
                            state <= READY;
                        else
                            idx <= idx + 8'd1;
                    end
                    READY: begin
                        // The exit test uses the count before any eat on this edge.
                        if (crux_left == 3'd0)
                            state <= DONE;
                        if (eat_ok) begin
                            food_map   <= food_map & clear_mask;
                            score      <= score_next;
                            eaten      <= 1'b1;
                            eaten_kind <= pos_code;
                            if (pos_code == 2'b11)
                                crux_left <= crux_left - 3'd1;
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FOOD_CONSUMER_REMAIN_EN
    logic [7:0] left_cnt;

    always_ff @(posedge clk) begin
        if (rst || load)
            left_cnt <= 8'd0;
        else if ((state == SCAN) && (scan_code != 2'b00))
            left_cnt <= left_cnt + 8'd1;
        else if (eat_ok)
            left_cnt <= left_cnt - 8'd1;
    end

    assign food_left = left_cnt;
`else
    assign food_left = 8'd0;
`endif

endmodule

// File: tb/tb_food_consumer.sv
// tb/tb_food_consumer.sv - table, directed and randomized checks of food_consumer against a map-level model.
module tb_food_consumer;

    logic         clk = 1'b0;
    logic         rst, load, pos_valid;
    logic [299:0] food_in;
    logic [3:0]   pos_x, pos_y;

    logic [299:0] food_map, s_food_map;
    logic         ready, eaten, win, s_ready, s_eaten, s_win;
    logic [1:0]   eaten_kind, s_eaten_kind;
    logic [15:0]  score;
    logic [3:0]   s_score;
    logic [2:0]   crux_left, s_crux_left;
    logic [7:0]   food_left, s_food_left;

    always #5 clk = ~clk;

    food_consumer #(.SCORE_W(16)) dut (
        .clk(clk), .rst(rst), .food_in(food_in), .load(load), .pos_valid(pos_valid),
        .pos_x(pos_x), .pos_y(pos_y), .food_map(food_map), .ready(ready), .eaten(eaten),
        .eaten_kind(eaten_kind), .score(score), .crux_left(crux_left), .win(win),
        .food_left(food_left)
    );

    food_consumer #(.SCORE_W(4)) dut_sat (
        .clk(clk), .rst(rst), .food_in(food_in), .load(load), .pos_valid(pos_valid),
        .pos_x(pos_x), .pos_y(pos_y), .food_map(s_food_map), .ready(s_ready), .eaten(s_eaten),
        .eaten_kind(s_eaten_kind), .score(s_score), .crux_left(s_crux_left), .win(s_win),
        .food_left(s_food_left)
    );

`ifdef FOOD_CONSUMER_REMAIN_EN
    localparam bit REMAIN = 1'b1;
`else
    localparam bit REMAIN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 scanning, 2 playing, 3 won.
    logic [1:0] m_map [150];
    int ph, scan_left, tot_crux, tot_left, m_crux, m_left, m_score16, m_score4, m_kind;
    bit m_eaten;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [299:0] map_vec();
        logic [299:0] v;
        for (int i = 0; i < 150; i++) v[2*i +: 2] = m_map[i];
        return v;
    endfunction

    task automatic model_edge();
        bit to_done;
        int c, pts;
        m_eaten = 0;
        m_kind  = 0;
        if (rst) begin
            ph = 0; m_score16 = 0; m_score4 = 0; m_crux = 0; m_left = 0;
            for (int i = 0; i < 150; i++) m_map[i] = 2'b00;
        end else if (load) begin
            tot_crux = 0; tot_left = 0;
            for (int i = 0; i < 150; i++) begin
                m_map[i] = food_in[2*i +: 2];
                if (m_map[i] == 2'b11) tot_crux++;
                if (m_map[i] != 2'b00) tot_left++;
            end
            m_crux = 0; m_left = 0; ph = 1; scan_left = 150;
        end else if (ph == 1) begin
            scan_left--;
            if (scan_left == 0) begin
                ph = 2; m_crux = tot_crux; m_left = tot_left;
            end
        end else if (ph == 2) begin
            to_done = (m_crux == 0);
            if (pos_valid && pos_x <= 9 && pos_y <= 14) begin
                c = int'(pos_y) * 10 + int'(pos_x);
                if (m_map[c] != 2'b00) begin
                    m_eaten = 1;
                    m_kind  = int'(m_map[c]);
                    pts = (m_kind == 1) ? 1 : (m_kind == 2) ? 5 : 10;
                    m_score16 = (m_score16 + pts > 65535) ? 65535 : m_score16 + pts;
                    m_score4  = (m_score4 + pts > 15) ? 15 : m_score4 + pts;
                    if (m_kind == 3) m_crux--;
                    m_left--;
                    m_map[c] = 2'b00;
                end
            end
            if (to_done) ph = 3;
        end
    endtask

    task automatic check_model();
        check("ready", ready, ph == 2);
        check("win", win, ph == 3);
        check("eaten", eaten, m_eaten);
        check("eaten_kind", eaten_kind, m_kind);
        check("score", score, m_score16);
        check("sat_score", s_score, m_score4);
        check("sat_eaten", s_eaten, m_eaten);
        check("food_map", food_map, map_vec());
        if (ph != 1) begin
            check("crux_left", crux_left, m_crux);
            check("food_left", food_left, REMAIN ? m_left : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_load(input logic [299:0] v);
        food_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        check_model();
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 400) begin
            tick();
            check_model();
            n++;
        end
        check(name, n, 150);
    endtask

    function automatic logic [299:0] rand_map();
        logic [299:0] v;
        int k;
        for (int i = 0; i < 150; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
        k = $urandom_range(0, 4);
        for (int j = 0; j < k; j++) v[2*$urandom_range(0, 149) +: 2] = 2'b11;
        return v;
    endfunction

    typedef struct {
        bit v;
        int x, y;
        bit e;
        int k, sc, ss;
        bit w;
    } row_t;

    row_t tbl [9];
    logic [299:0] mv;

    initial begin
        tbl[0] = '{1, 10, 0,  0, 0,  0,  0, 0};
        tbl[1] = '{1, 0,  15, 0, 0,  0,  0, 0};
        tbl[2] = '{1, 2,  1,  1, 2,  5,  5, 0};
        tbl[3] = '{1, 2,  1,  0, 0,  5,  5, 0};
        tbl[4] = '{1, 3,  0,  1, 1,  6,  6, 0};
        tbl[5] = '{0, 4,  0,  0, 0,  6,  6, 0};
        tbl[6] = '{1, 0,  0,  1, 3,  16, 15, 0};
        tbl[7] = '{0, 0,  0,  0, 0,  16, 15, 1};
        tbl[8] = '{1, 1,  0,  0, 0,  16, 15, 1};

        rst = 1'b1; load = 1'b1; pos_valid = 1'b0; pos_x = 4'd0; pos_y = 4'd0;
        food_in = {150{2'b01}};
        tick();
        load = 1'b0;
        check("reset_map", food_map, 300'd0);
        check("reset_ready", ready, 1'b0);
        check("reset_score", score, 16'd0);
        check_model();
        rst = 1'b0;

        // All normal food, one crux at cell 0 and a rare cell at 12.
        mv = {150{2'b01}};
        mv[1:0]   = 2'b11;
        mv[25:24] = 2'b10;
        do_load(mv);
        wait_ready("scan_latency");
        check("crux_after_scan", crux_left, 3'd1);
        check("food_left_after_scan", food_left, REMAIN ? 8'd150 : 8'd0);
        for (int i = 0; i < 9; i++) begin
            pos_valid = tbl[i].v; pos_x = 4'(tbl[i].x); pos_y = 4'(tbl[i].y);
            tick();
            check("tbl_eaten", eaten, tbl[i].e);
            check("tbl_kind", eaten_kind, tbl[i].k);
            check("tbl_score", score, tbl[i].sc);
            check("tbl_sat_score", s_score, tbl[i].ss);
            check("tbl_win", win, tbl[i].w);
            check_model();
        end
        pos_valid = 1'b0;
        check("rare_cell_cleared", food_map[25:24], 2'b00);

        // Reload mid-scan, then reset partway into the second scan.
        do_load(rand_map());
        repeat (70) begin tick(); check_model(); end
        do_load(rand_map());
        repeat (30) begin tick(); check_model(); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_map", food_map, 300'd0);
        check("abort_score", score, 16'd0);
        check("abort_ready", ready, 1'b0);
        check("abort_crux", crux_left, 3'd0);
        check("abort_food_left", food_left, 8'd0);
        check_model();
        mv = {150{2'b01}};
        mv[299:298] = 2'b11;
        do_load(mv);
        wait_ready("rescan_latency");

        // Rare eats: the 4-bit score saturates at 15.
        mv = {150{2'b10}};
        mv[299:298] = 2'b11;
        do_load(mv);
        wait_ready("rare_scan_latency");
        for (int i = 0; i < 5; i++) begin
            pos_valid = 1'b1; pos_x = 4'(i); pos_y = 4'd0;
            tick();
            check("rare_score", score, 5 * (i + 1));
            check("rare_sat_score", s_score, (5 * (i + 1) > 15) ? 15 : 5 * (i + 1));
            check_model();
        end
        // Load and an eat on the same edge: the load wins.
        pos_x = 4'd5; load = 1'b1; food_in = mv;
        tick();
        load = 1'b0; pos_valid = 1'b0;
        check("load_wins_eaten", eaten, 1'b0);
        check("load_wins_score", score, 16'd25);
        check_model();

        for (int r = 0; r < 6; r++) begin
            do_load(rand_map());
            for (int c = 0; c < 550; c++) begin
                rst       = ($urandom_range(0, 599) == 0);
                load      = ($urandom_range(0, 299) == 0);
                food_in   = rand_map();
                pos_valid = $urandom_range(0, 1) == 1;
                pos_x     = 4'($urandom_range(0, 10));
                pos_y     = 4'($urandom_range(0, 15));
                tick();
                check_model();
            end
            rst = 1'b0; load = 1'b0; pos_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/food_consumer.md
FOOD_CONSUMER -- requirements
Module: food_consumer

Interface
REQ-001 SHALL have parameter SCORE_W, default 16, width of score counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port food_in  input  300  map from generator; cell i at bits [2i+1:2i]; 00 empty, 01 normal, 10 rare, 11 crux.
REQ-005 SHALL have port load  input  1  one-cycle strobe: capture food_in, start scan (driven on generator busy falling).
REQ-006 SHALL have port pos_valid  input  1  player position valid this cycle.
REQ-007 SHALL have port pos_x  input  4  column, legal 0..9.
REQ-008 SHALL have port pos_y  input  4  row, legal 0..14; cell index = pos_y*10+pos_x.
REQ-009 SHALL have port food_map  output  300  current map after consumption, for renderer.
REQ-010 SHALL have port ready  output  1  state READY.
REQ-011 SHALL have port eaten  output  1  one-cycle pulse, food consumed.
REQ-012 SHALL have port eaten_kind  output  2  code of consumed cell, valid with eaten.
REQ-013 SHALL have port score  output  SCORE_W  accumulated score.
REQ-014 SHALL have port crux_left  output  3  crux cells remaining (0..4).
REQ-015 SHALL have port win  output  1  state DONE.
REQ-016 SHALL have port food_left  output  8  non-empty cells remaining (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE, SCAN, READY, DONE.
REQ-018 load in any state SHALL copy food_in into food_map, clear scan index, crux_left, food_left, enter SCAN; score unchanged.
REQ-019 SCAN SHALL examine one cell per cycle, index 0..149; crux_left +1 per 11 cell, food_left +1 per non-00 cell.
REQ-020 After cell 149 examined (150 cycles after load edge), SHALL enter READY; index SHALL NOT exceed 149.
REQ-021 READY with crux_left==0 SHALL go to DONE next cycle.
REQ-022 In READY, pos_valid with legal coordinates and non-empty cell SHALL, on the same edge, clear the cell to 00, add points to score, register eaten=1 and eaten_kind=cell code.
REQ-023 Points: 01 -> +1, 10 -> +5, 11 -> +10; score SHALL saturate at all-ones.
REQ-024 Eating a crux cell SHALL decrement crux_left; eating any cell SHALL decrement food_left.
REQ-025 Empty cell, out-of-range coordinates (x>9 or y>14), or pos_valid outside READY SHALL cause no state, map, or score change and eaten=0.
REQ-026 Consecutive cycles with pos_valid SHALL each be processed; a repeated position on the next cycle finds 00 and yields no pulse.
REQ-027 eaten SHALL be low in every cycle not following an accepted eat.
REQ-028 DONE SHALL hold win=1, ignore pos_valid, and leave only on load or rst.
REQ-029 load and pos_valid in the same cycle: load SHALL win, the eat is dropped.

Reset
REQ-030 rst SHALL force IDLE, food_map=0, score=0, crux_left=0, food_left=0, eaten=0, eaten_kind=0, ready=0, win=0, index=0; rst overrides load.
REQ-031 rst mid-SCAN SHALL abort the scan; a later load restarts from index 0.

Configuration
REQ-032 With FOOD_CONSUMER_REMAIN_EN defined, SHALL implement food_left per REQ-019/REQ-024.
REQ-033 Without FOOD_CONSUMER_REMAIN_EN, food_left SHALL be tied to 0 and its counter SHALL not be built; all other behaviour unchanged.

Verification
REQ-034 Map all 01 except cell 0=11; load -> ready rises 150 cycles later, crux_left=1, food_left=150 (macro on).
REQ-035 Same map, READY, pos (0,0) -> eaten=1, eaten_kind=11, score=10, crux_left=0, next cycle win=1; later pos (1,0) ignored.
REQ-036 Cell 12=10, pos (2,1) on two consecutive cycles -> one eaten pulse, score +5, food_map[25:24]=00.
REQ-037 pos (10,0) and (0,15) with pos_valid in READY -> no eaten, score unchanged.
REQ-038 load at scan index 70, then rst at index 30 of the new scan -> IDLE, all outputs 0; next load -> full 150-cycle scan.
REQ-039 score preset near max via repeated rare eats with SCORE_W=4 -> score saturates at 15.
